segment_scan_decoder: RTL and testbench

- Snoops a multiplexed, active-low 7-segment display bus (shared segment lines plus per-digit anode strobes) and recovers the hex nibble shown on each digit.
- Inverse of the team's hex-to-segment encoder; used by self-check and loopback logic to read back what the display is showing.
- Sequential: synchronizes the bus, qualifies stable strobes, decodes, assembles digits into frames and flags bad patterns.

---
 rtl/segment_scan_decoder_if.sv | 26 ++
 rtl/segment_scan_decoder.sv | 182 ++++++++++++++++++
 tb/tb_segment_scan_decoder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/segment_scan_decoder_if.sv
// Snoop-side bundle for segment_scan_decoder: display bus in, decoded state out.
interface segment_scan_decoder_if #(
    parameter int NDIG = 4
);
    logic [6:0]        segment;
    logic [NDIG-1:0]   anode;
    logic              err_clr;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   digit_valid;
    logic              frame_valid;
    logic              err_pulse;
    logic              err_sticky;
    logic [NDIG-1:0]   blank;

    modport master (
        output segment, anode, err_clr,
        input  digits, digit_valid, frame_valid,
        input  err_pulse, err_sticky, blank
    );

    modport slave (
        input  segment, anode, err_clr,
        output digits, digit_valid, frame_valid,
        output err_pulse, err_sticky, blank
    );
endinterface

// File: rtl/segment_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus.
// Define SEGMENT_SCAN_BLANK_EN to accept 7F as a legal blank digit.
module segment_scan_decoder #(
    parameter int NDIG   = 4,
    parameter int STABLE = 4
) (
    input logic                   clk,
    input logic                   reset,
    segment_scan_decoder_if.slave bus
);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, TRACK, CAPTURED} state_t;

    logic [6:0]        seg_m, seg_s;
    logic [NDIG-1:0]   an_m, an_s;
    state_t            state, state_n;
    logic [7:0]        cnt, cnt_n;
    logic [IW-1:0]     idx, idx_n, sidx;
    logic [6:0]        pat, pat_n;
    logic              strobe, change, accept;
    logic [4:0]        dec;
    logic              code_ok, is_blank, take, full;
    logic [NDIG-1:0]   sel, mask, mask_or;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   digit_valid;
    logic              frame_valid, err_pulse, err_sticky;

    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        r = '0;
        case (p)
            7'h40: r = {1'b1, 4'h0};
            7'h79: r = {1'b1, 4'h1};
            7'h24: r = {1'b1, 4'h2};
            7'h30: r = {1'b1, 4'h3};
            7'h19: r = {1'b1, 4'h4};
            7'h12: r = {1'b1, 4'h5};
            7'h02: r = {1'b1, 4'h6};
            7'h78: r = {1'b1, 4'h7};
            7'h00: r = {1'b1, 4'h8};
            7'h18: r = {1'b1, 4'h9};
            7'h08: r = {1'b1, 4'hA};
            7'h03: r = {1'b1, 4'hB};
            7'h46: r = {1'b1, 4'hC};
            7'h21: r = {1'b1, 4'hD};
            7'h06: r = {1'b1, 4'hE};
            7'h0E: r = {1'b1, 4'hF};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_m <= '0;
            seg_s <= '0;
            an_m  <= '0;
            an_s  <= '0;
        end else begin
            seg_m <= bus.segment;
            seg_s <= seg_m;
            an_m  <= bus.anode;
            an_s  <= an_m;
        end
    end

    always_comb begin
        strobe = $onehot(~an_s);
        sidx   = '0;
        for (int i = 0; i < NDIG; i++)
            if (!an_s[i]) sidx = IW'(i);
    end

    assign change = !strobe || (sidx != idx) || (seg_s != pat);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            pat   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            pat   <= pat_n;
        end
    end

    // A run of identical samples is accepted exactly once, when it reaches STABLE.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        pat_n   = pat;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                if (strobe) begin
                    state_n = TRACK;
                    idx_n   = sidx;
                    pat_n   = seg_s;
                    cnt_n   = 8'd1;
                end
            end
            TRACK, CAPTURED: begin
                if (change) begin
                    idx_n   = sidx;
                    pat_n   = seg_s;
                    state_n = strobe ? TRACK : IDLE;
                    cnt_n   = strobe ? 8'd1 : 8'd0;
                end else if (state == TRACK) begin
                    cnt_n = cnt + 8'd1;
                    if (cnt == 8'(STABLE - 1)) begin
                        accept  = 1'b1;
                        state_n = CAPTURED;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign dec     = decode(pat);
    assign code_ok = dec[4];
`ifdef SEGMENT_SCAN_BLANK_EN
    assign is_blank = (pat == 7'h7F);
`else
    assign is_blank = 1'b0;
`endif
    assign sel     = NDIG'(1) << idx;
    assign take    = accept && (code_ok || is_blank);
    assign mask_or = mask | sel;
    assign full    = take && (&mask_or);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits      <= '0;
            digit_valid <= '0;
            mask        <= '0;
            frame_valid <= 1'b0;
            err_pulse   <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            frame_valid <= full;
            err_pulse   <= accept && !code_ok && !is_blank;
            err_sticky  <= err_pulse || (err_sticky && !bus.err_clr);
            if (take) begin
                digit_valid <= digit_valid | sel;
                // A digit already in the closing frame starts the next one.
                if (full)
                    mask <= mask[idx] ? sel : '0;
                else
                    mask <= mask_or;
                if (code_ok)
                    digits[4*idx +: 4] <= dec[3:0];
            end
        end
    end

`ifdef SEGMENT_SCAN_BLANK_EN
    logic [NDIG-1:0] blank;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            blank <= '0;
        else if (accept && code_ok)
            blank[idx] <= 1'b0;
        else if (accept && is_blank)
            blank[idx] <= 1'b1;
    end
    assign bus.blank = blank;
`else
    assign bus.blank = '0;
`endif

    assign bus.digits      = digits;
    assign bus.digit_valid = digit_valid;
    assign bus.frame_valid = frame_valid;
    assign bus.err_pulse   = err_pulse;
    assign bus.err_sticky  = err_sticky;
endmodule

// File: tb/tb_segment_scan_decoder.sv
// Random and directed scan stimulus against a run-length model of the decoder.
// Build with or without SEGMENT_SCAN_BLANK_EN; the model follows the same macro.
module tb_segment_scan_decoder;
    localparam int NDIG   = 4;
    localparam int STABLE = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    segment_scan_decoder_if #(.NDIG(NDIG)) bus ();

    segment_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [6:0] pat_tbl [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [6:0]      hs [$];
    logic [NDIG-1:0] ha [$];
    logic            hc [$];

    logic [4*NDIG-1:0] m_dig;
    logic [NDIG-1:0]   m_dv, m_mask, m_blank;
    logic              m_frame, m_errp, m_errs;

    function automatic bit strobe_of(logic [NDIG-1:0] a);
        return $countones(~a) == 1;
    endfunction

    function automatic int where(logic [NDIG-1:0] a);
        for (int i = 0; i < NDIG; i++)
            if (!a[i]) return i;
        return 0;
    endfunction

    task automatic model_clear();
        hs.delete();
        ha.delete();
        hc.delete();
        m_dig   = '0;
        m_dv    = '0;
        m_mask  = '0;
        m_blank = '0;
        m_frame = 1'b0;
        m_errp  = 1'b0;
        m_errs  = 1'b0;
    endtask

    task automatic capture(int i);
        m_dv[i]   = 1'b1;
        m_mask[i] = 1'b1;
        if (&m_mask) begin
            m_frame = 1'b1;
            m_mask  = '0;
        end
    endtask

    // Outputs change at edge t when the pin run ending at edge t-2 is exactly STABLE long.
    task automatic model_edge();
        int t = hs.size();
        int k = t - 2;
        bit acc = 1'b0;
        int found = -1;
        int i;
        logic [6:0] p;
        logic [NDIG-1:0] a;
        m_errs  = m_errp | (m_errs & ~hc[t-1]);
        m_frame = 1'b0;
        m_errp  = 1'b0;
        if (k >= STABLE) begin
            p   = hs[k-1];
            a   = ha[k-1];
            acc = strobe_of(a);
            for (int j = k - STABLE + 1; j <= k; j++)
                if (hs[j-1] !== p || ha[j-1] !== a) acc = 1'b0;
            if (k - STABLE >= 1 && hs[k-STABLE-1] === p && ha[k-STABLE-1] === a)
                acc = 1'b0;
        end
        if (acc) begin
            i = where(a);
            for (int n = 0; n < 16; n++)
                if (pat_tbl[n] == p) found = n;
            if (found >= 0) begin
                m_dig[4*i +: 4] = found[3:0];
                m_blank[i] = 1'b0;
                capture(i);
            end
`ifdef SEGMENT_SCAN_BLANK_EN
            else if (p == 7'h7F) begin
                m_blank[i] = 1'b1;
                capture(i);
            end
`endif
            else begin
                m_errp = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("digits", bus.digits, m_dig);
        chk("digit_valid", bus.digit_valid, m_dv);
        chk("frame_valid", bus.frame_valid, m_frame);
        chk("err_pulse", bus.err_pulse, m_errp);
        chk("err_sticky", bus.err_sticky, m_errs);
        chk("blank", bus.blank, m_blank);
    endtask

    task automatic edge_rec();
        @(posedge clk);
        ha.push_back(bus.anode);
        hs.push_back(bus.segment);
        hc.push_back(bus.err_clr);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic cyc(logic [NDIG-1:0] a, logic [6:0] s, logic c);
        @(negedge clk);
        bus.anode   = a;
        bus.segment = s;
        bus.err_clr = c;
        edge_rec();
    endtask

    task automatic hold(logic [NDIG-1:0] a, logic [6:0] s, int n, bit rclr);
        for (int i = 0; i < n; i++)
            cyc(a, s, rclr ? ($urandom_range(0, 7) == 0) : 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_digits", bus.digits, '0);
        chk("rst_digit_valid", bus.digit_valid, '0);
        chk("rst_frame_valid", bus.frame_valid, '0);
        chk("rst_err_pulse", bus.err_pulse, '0);
        chk("rst_err_sticky", bus.err_sticky, '0);
        chk("rst_blank", bus.blank, '0);
        @(negedge clk);
        reset       = 1'b0;
        bus.anode   = '1;
        bus.segment = 7'h7F;
        bus.err_clr = 1'b0;
        model_clear();
        edge_rec();
    endtask

    task automatic rand_holds(int n);
        logic [NDIG-1:0] a;
        logic [6:0] s;
        int r;
        for (int h = 0; h < n; h++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = ~(NDIG'(1) << $urandom_range(0, NDIG - 1));
            else if (r == 7) a = '1;
            else             a = NDIG'($urandom);
            r = $urandom_range(0, 9);
            if (r < 7)       s = pat_tbl[$urandom_range(0, 15)];
            else if (r == 7) s = 7'h7F;
            else             s = 7'($urandom);
            hold(a, s, $urandom_range(1, STABLE + 5), 1'b1);
        end
    endtask

    initial begin
        bus.anode   = '1;
        bus.segment = 7'h7F;
        bus.err_clr = 1'b0;
        model_clear();
        do_reset();

        hold(4'b1110, 7'h79, 10, 1'b0);
        hold(4'b1101, 7'h24, 10, 1'b0);
        hold(4'b1011, 7'h30, 10, 1'b0);
        hold(4'b0111, 7'h19, 10, 1'b0);
        chk("tp1_digits", bus.digits, 16'h4321);
        chk("tp1_valid", bus.digit_valid, 4'hF);

        do_reset();
        hold(4'b1110, 7'h40, 3, 1'b0);
        hold(4'b1111, 7'h40, 6, 1'b0);
        chk("tp2_valid", bus.digit_valid, 4'h0);

        hold(4'b1101, 7'h7E, 6, 1'b0);
        cyc(4'b1101, 7'h7E, 1'b1);
        chk("tp3_sticky_set_wins", bus.err_sticky, 1'b1);
        hold(4'b1101, 7'h7E, 2, 1'b0);
        cyc(4'b1101, 7'h7E, 1'b1);
        chk("tp3_sticky_clr", bus.err_sticky, 1'b0);

        hold(4'b1100, 7'h24, 8, 1'b0);
        hold(4'b1111, 7'h24, 8, 1'b0);
        chk("tp4_valid", bus.digit_valid, 4'h0);

        hold(4'b1011, 7'h0E, 20, 1'b0);
        chk("tp5_digit_f", bus.digits[11:8], 4'hF);
        hold(4'b1011, 7'h06, STABLE + 2, 1'b0);
        chk("tp5_digit_e", bus.digits[11:8], 4'hE);

        hold(4'b0111, 7'h7F, 8, 1'b0);
`ifdef SEGMENT_SCAN_BLANK_EN
        chk("tp6_blank", bus.blank, 4'b1000);
`else
        chk("tp6_blank", bus.blank, 4'b0000);
`endif

        rand_holds(400);
        do_reset();
        rand_holds(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
